// File: rtl/secuenciador_notas.sv
// secuenciador_notas: keyboard/ROM note scheduler driving divisor_frecuencia.freq
// Optional song repeat enabled by defining SECUENCIADOR_LOOP_EN.
module secuenciador_notas #(
  parameter int TICKS_PER_BEAT = 12_000_000,
  parameter int GAP_TICKS      = 600_000,
  parameter int SONG_LEN       = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  teclas,
  input  logic        play,
  input  logic        stop,
  input  logic        loop,
  output logic [31:0] freq,
  output logic        busy,
  output logic [5:0]  note_idx,
  output logic        done
);
  localparam int CW = $clog2(7 * TICKS_PER_BEAT + 1);
  typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n, play_last;
  logic [31:0] freq_n;
  logic [5:0] idx_n;
  logic [2:0] code, dur;
  logic done_n, end_hit;
  // ROM entries are {note,dur}, so each octal digit is one field
  function automatic logic [5:0] rom(input logic [5:0] a);
    case (a)
      6'd0, 6'd3: rom = 6'o11;
      6'd1:       rom = 6'o21;
      6'd2:       rom = 6'o31;
      6'd4:       rom = 6'o01;
      6'd5:       rom = 6'o52;
      default:    rom = 6'o00;
    endcase
  endfunction
  function automatic logic [31:0] tone(input logic [2:0] c);
    case (c)
      3'd1:    tone = 32'd1046;
      3'd2:    tone = 32'd1174;
      3'd3:    tone = 32'd1318;
      3'd4:    tone = 32'd1396;
      3'd5:    tone = 32'd1567;
      3'd6:    tone = 32'd1760;
      3'd7:    tone = 32'd1975;
      default: tone = 32'd0;
    endcase
  endfunction
  function automatic logic [2:0] lowest_key(input logic [6:0] t);
    lowest_key = 3'd0;
    for (int i = 6; i >= 0; i--) if (t[i]) lowest_key = 3'(i + 1);
  endfunction
  assign {code, dur} = rom(note_idx);
  assign play_last = CW'(int'(dur) * TICKS_PER_BEAT - GAP_TICKS - 1);
  assign busy = state != IDLE;
`ifndef SECUENCIADOR_LOOP_EN
  logic unused_loop;
  assign unused_loop = loop;
`endif
  always_comb begin
    state_n = state;
    freq_n = '0;
    idx_n = note_idx;
    done_n = 1'b0;
    cnt_n = '0;
    end_hit = 1'b0;
    case (state)
      IDLE: begin
        freq_n = tone(lowest_key(teclas));
        if (play && !stop) begin
          state_n = LOAD;
          idx_n = '0;
          freq_n = '0;
        end
      end
      LOAD: begin
        end_hit = dur == 3'd0;
        state_n = end_hit ? LOAD : PLAY;
        freq_n = end_hit ? 32'd0 : tone(code);
      end
      PLAY: begin
        state_n = cnt == play_last ? GAP : PLAY;
        freq_n = cnt == play_last ? 32'd0 : tone(code);
        cnt_n = cnt == play_last ? '0 : cnt + 1'b1;
      end
      GAP: begin
        cnt_n = cnt + 1'b1;
        if (cnt == CW'(GAP_TICKS - 1)) begin
          cnt_n = '0;
          end_hit = note_idx == 6'(SONG_LEN - 1);
          state_n = LOAD;
          idx_n = end_hit ? note_idx : note_idx + 6'd1;
        end
      end
    endcase
    if (end_hit) begin
      state_n = IDLE;
      idx_n = '0;
      freq_n = '0;
      done_n = 1'b1;
`ifdef SECUENCIADOR_LOOP_EN
      if (loop) begin
        state_n = LOAD;
        done_n = 1'b0;
      end
`endif
    end
    if (stop && state != IDLE) begin
      state_n = IDLE;
      idx_n = '0;
      freq_n = '0;
      done_n = 1'b0;
      cnt_n = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      freq <= '0;
      note_idx <= '0;
      done <= 1'b0;
      cnt <= '0;
    end else begin
      state <= state_n;
      freq <= freq_n;
      note_idx <= idx_n;
      done <= done_n;
      cnt <= cnt_n;
    end
  end
endmodule

// File: tb/tb_secuenciador_notas.sv
// tb_secuenciador_notas: random/directed bench against a schedule-queue reference model
module tb_secuenciador_notas;
  localparam int T = 10, G = 2, SL = 16;
  logic clk = 1'b0, reset, play, stop, loop;
  logic [6:0] teclas;
  logic [31:0] freq;
  logic busy, done;
  logic [5:0] note_idx;
  typedef struct packed {logic [31:0] f; logic [5:0] i; logic b; logic d;} exp_t;
  exp_t q[$];
  exp_t e;
  int compared = 0, mismatched = 0, done_seen, guard;
  int rn[7] = '{1, 2, 3, 1, 0, 5, 0};
  int rd[7] = '{1, 1, 1, 1, 1, 2, 0};
  secuenciador_notas #(.TICKS_PER_BEAT(T), .GAP_TICKS(G), .SONG_LEN(SL)) dut (
    .clk(clk), .reset(reset), .teclas(teclas), .play(play), .stop(stop), .loop(loop),
    .freq(freq), .busy(busy), .note_idx(note_idx), .done(done));
  always #5 clk = ~clk;
  function automatic logic [31:0] tbl(int n);
    case (n)
      1: return 32'd1046;
      2: return 32'd1174;
      3: return 32'd1318;
      4: return 32'd1396;
      5: return 32'd1567;
      6: return 32'd1760;
      7: return 32'd1975;
      default: return 32'd0;
    endcase
  endfunction
  function automatic logic [31:0] key_tone(logic [6:0] t);
    for (int i = 0; i < 7; i++) if (t[i]) return tbl(i + 1);
    return 32'd0;
  endfunction
  function automatic exp_t mk(logic [31:0] f, int i, logic b, logic d);
    mk.f = f;
    mk.i = 6'(i);
    mk.b = b;
    mk.d = d;
  endfunction
  // Whole song unrolled into one expected output per clock cycle
  task automatic fill_song();
    q.delete();
    for (int k = 0; k < SL; k++) begin
      int n, d;
      n = k < 7 ? rn[k] : 0;
      d = k < 7 ? rd[k] : 0;
      q.push_back(mk(0, k, 1, 0));
      if (d == 0) break;
      repeat (d * T - G) q.push_back(mk(tbl(n), k, 1, 0));
      repeat (G) q.push_back(mk(0, k, 1, 0));
    end
    q.push_back(mk(0, 0, 0, 1));
  endtask
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    if (reset) begin
      q.delete();
      e = mk(0, 0, 0, 0);
    end else if (e.b) begin
      if (stop || q.size() == 0) begin
        q.delete();
        e = mk(0, 0, 0, 0);
      end else e = q.pop_front();
    end else if (play && !stop) begin
      fill_song();
      e = q.pop_front();
    end else e = mk(key_tone(teclas), 0, 0, 0);
    @(negedge clk);
    chk("freq", freq, e.f);
    chk("note_idx", 32'(note_idx), 32'(e.i));
    chk("busy", 32'(busy), 32'(e.b));
    chk("done", 32'(done), 32'(e.d));
  endtask
  initial begin
    e = mk(0, 0, 0, 0);
    reset = 1'b1; play = 1'b0; stop = 1'b0; loop = 1'b0; teclas = '0;
    @(negedge clk);
    repeat (3) cyc();
    reset = 1'b0;
    cyc();
    teclas = 7'b0010100;
    cyc();
    chk("keys_lowest", freq, 32'd1318);
    teclas = '0;
    cyc();
    chk("keys_off", freq, 32'd0);
    play = 1'b1;
    cyc();
    play = 1'b0;
    done_seen = 0;
    repeat (100) begin
      teclas = 7'($urandom);
      play = e.b ? 1'($urandom) : 1'b0;
      cyc();
      if (done) done_seen++;
    end
    chk("done_once", 32'(done_seen), 32'd1);
    play = 1'b0;
    teclas = '0;
    cyc();
    play = 1'b1;
    cyc();
    play = 1'b0;
    guard = 0;
    while (!(e.i == 6'd1 && e.f != 0) && guard < 200) begin
      cyc();
      guard++;
    end
    chk("wait_entry1", 32'(guard < 200), 32'd1);
    repeat (2) cyc();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk("stop_busy", 32'(busy), 32'd0);
    chk("stop_done", 32'(done), 32'd0);
    repeat (2000) begin
      teclas = 7'($urandom);
      play = $urandom_range(0, 7) == 0;
      stop = $urandom_range(0, 99) == 0;
      reset = $urandom_range(0, 399) == 0;
      loop = 1'($urandom);
      cyc();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
